// File: rtl/pe_act_queue_if.sv
// Handshake bundle between the PE network interface / PE controller and the
// per-PE activation queue.
interface pe_act_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     push_act;
  logic [ADDR_W+DATA_W-1:0] act;
  logic                     pop_act;
  logic                     flush;
  logic                     act_valid;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  logic                     full;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         max_count;
  logic                     overflow_err;
  logic                     underflow_err;

  modport master (
    output push_act, act, pop_act, flush,
    input  act_valid, head_addr, head_data, full, count, max_count,
           overflow_err, underflow_err
  );

  modport slave (
    input  push_act, act, pop_act, flush,
    output act_valid, head_addr, head_data, full, count, max_count,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/pe_act_queue.sv
// Per-PE first-word-fall-through activation queue with occupancy,
// high-watermark and sticky over/underflow reporting.
module pe_act_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  pe_act_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] max_q;
  logic             ovf_q;
  logic             unf_q;

  logic             empty;
  logic             is_full;
  logic             do_push;
  logic             do_pop;
  logic             ovf_set;
  logic             unf_set;
  logic [CNT_W-1:0] count_nxt;
  logic [ENT_W-1:0] head;

  // A pop at full frees the slot the same-cycle push needs, so it is accepted.
  always_comb begin
    empty     = (count_q == '0);
    is_full   = (count_q == DEPTH_C);
    do_push   = q.push_act && !q.flush && (!is_full || q.pop_act);
    do_pop    = q.pop_act  && !q.flush && !empty;
    ovf_set   = q.push_act && !q.flush && is_full && !q.pop_act;
    unf_set   = q.pop_act  && !q.flush && empty;
    count_nxt = count_q;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      max_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (q.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      max_q   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      if (count_nxt > max_q) max_q <= count_nxt;
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  // Storage carries no reset; contents are only observable through rd_ptr
  // while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= q.act;
  end

  always_comb begin
    head            = empty ? '0 : mem[rd_ptr];
    q.act_valid     = !empty;
    q.head_addr     = head[ENT_W-1:DATA_W];
    q.head_data     = head[DATA_W-1:0];
    q.full          = is_full;
    q.count         = count_q;
    q.max_count     = max_q;
    q.overflow_err  = ovf_q;
    q.underflow_err = unf_q;
  end
endmodule

// File: tb/tb_pe_act_queue.sv
// Directed bench for pe_act_queue: a queue-based behavioural model checked
// every cycle, plus literal expectations at the interesting points.
module tb_pe_act_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int ENT_W  = ADDR_W + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_act_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pe_act_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    total_cnt++;
    if (act_v === exp_v) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act_v, exp_v, $time);
  endtask

  // Behavioural model: a plain queue of entries plus watermark and flags.
  logic [ENT_W-1:0] m_q [$];
  int               m_max = 0;
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;
  int               m_sz;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_max = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (bus.flush) begin
      m_q.delete();
      m_max = 0;
    end else begin
      m_sz = m_q.size();
      if (bus.pop_act && m_sz == 0) m_unf = 1'b1;
      if (bus.push_act && m_sz == DEPTH && !bus.pop_act) m_ovf = 1'b1;
      if (bus.pop_act && m_sz > 0) void'(m_q.pop_front());
      if (bus.push_act && (m_sz < DEPTH || bus.pop_act)) m_q.push_back(bus.act);
      if (m_q.size() > m_max) m_max = m_q.size();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [ENT_W-1:0] eh;
      eh = (m_q.size() > 0) ? m_q[0] : '0;
      chk("m_valid", 32'(bus.act_valid), 32'(m_q.size() > 0));
      chk("m_count", 32'(bus.count), 32'(m_q.size()));
      chk("m_full", 32'(bus.full), 32'(m_q.size() == DEPTH));
      chk("m_max", 32'(bus.max_count), 32'(m_max));
      chk("m_haddr", 32'(bus.head_addr), 32'(eh[ENT_W-1:DATA_W]));
      chk("m_hdata", 32'(bus.head_data), 32'(eh[DATA_W-1:0]));
      chk("m_ovf", 32'(bus.overflow_err), 32'(m_ovf));
      chk("m_unf", 32'(bus.underflow_err), 32'(m_unf));
    end
  end

  // Drive one cycle of inputs, then return just after the active edge.
  task automatic step(input bit p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input bit po, input bit f);
    @(negedge clk);
    bus.push_act = p;
    bus.act      = {a, d};
    bus.pop_act  = po;
    bus.flush    = f;
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] exp_tail [4];

  initial begin
    bus.push_act = 1'b0;
    bus.act      = '0;
    bus.pop_act  = 1'b0;
    bus.flush    = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.act_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
    chk("rst_unf", 32'(bus.underflow_err), 32'd0);
    chk("rst_head", 32'({bus.head_addr, bus.head_data}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ordered push then pop.
    step(1, 6'd3, 16'h0011, 0, 0);
    chk("p1_valid", 32'(bus.act_valid), 32'd1);
    step(1, 6'd5, 16'h0022, 0, 0);
    step(1, 6'd7, 16'h0033, 0, 0);
    chk("p3_count", 32'(bus.count), 32'd3);
    chk("p3_max", 32'(bus.max_count), 32'd3);
    chk("p3_haddr", 32'(bus.head_addr), 32'd3);
    chk("p3_hdata", 32'(bus.head_data), 32'h0011);
    step(0, 0, 0, 1, 0);
    chk("pop1_head", 32'(bus.head_data), 32'h0022);
    chk("pop1_addr", 32'(bus.head_addr), 32'd5);
    step(0, 0, 0, 1, 0);
    chk("pop2_head", 32'(bus.head_data), 32'h0033);
    step(0, 0, 0, 1, 0);
    chk("pop3_valid", 32'(bus.act_valid), 32'd0);
    chk("pop3_unf", 32'(bus.underflow_err), 32'd0);

    // Fill, overflow, push+pop at full.
    for (int i = 0; i < 4; i++) step(1, 6'(i + 1), 16'(16'hA0 + i), 0, 0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd4);
    step(1, 6'd9, 16'h00BB, 0, 0);
    chk("ovf_flag", 32'(bus.overflow_err), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd4);
    chk("ovf_head", 32'(bus.head_data), 32'h00A0);
    step(1, 6'd10, 16'h00CC, 1, 0);
    chk("pp_full_count", 32'(bus.count), 32'd4);
    chk("pp_full_head", 32'(bus.head_data), 32'h00A1);
    exp_tail[0] = 16'h00A1; exp_tail[1] = 16'h00A2;
    exp_tail[2] = 16'h00A3; exp_tail[3] = 16'h00CC;
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", 32'(bus.head_data), 32'(exp_tail[i]));
      step(0, 0, 0, 1, 0);
    end
    chk("drain_empty", 32'(bus.act_valid), 32'd0);
    chk("drain_unf", 32'(bus.underflow_err), 32'd0);
    chk("drain_max", 32'(bus.max_count), 32'd4);

    // Reset the watermark, then alternate push/pop across the wrap point.
    step(0, 0, 0, 0, 1);
    chk("fl0_max", 32'(bus.max_count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1, 6'(i), 16'(i), 0, 0);
      chk("wrap_head", 32'(bus.head_data), 32'(i));
      chk("wrap_count", 32'(bus.count), 32'd1);
      step(0, 0, 0, 1, 0);
    end
    chk("wrap_max", 32'(bus.max_count), 32'd1);

    // Underflow and push+pop on empty.
    step(0, 0, 0, 1, 0);
    chk("unf_flag", 32'(bus.underflow_err), 32'd1);
    chk("unf_count", 32'(bus.count), 32'd0);
    step(1, 6'd9, 16'h0099, 1, 0);
    chk("ppe_count", 32'(bus.count), 32'd1);
    chk("ppe_head", 32'({bus.head_addr, bus.head_data}), 32'({6'd9, 16'h0099}));

    // Flush with a concurrent push.
    step(1, 6'd11, 16'h0111, 0, 0);
    step(1, 6'd12, 16'h0122, 0, 0);
    chk("prefl_count", 32'(bus.count), 32'd3);
    step(1, 6'd13, 16'h0133, 0, 1);
    chk("fl_count", 32'(bus.count), 32'd0);
    chk("fl_max", 32'(bus.max_count), 32'd0);
    chk("fl_valid", 32'(bus.act_valid), 32'd0);
    chk("fl_ovf", 32'(bus.overflow_err), 32'd1);
    chk("fl_unf", 32'(bus.underflow_err), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("postfl_count", 32'(bus.count), 32'd0);
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule

// File: doc/pe_act_queue.md
Name: pe_act_queue

Overview:
- Per-PE activation queue. Sits directly downstream of the PE network interface, which pushes BROADCAST activations {addr, data} into it.
- The PE controller pops entries from the head for MAC processing.
- Each pop makes the network interface release one upstream credit. Queue depth therefore matches the leaf-router FIFO depth, so the credit loop bounds occupancy.
- Adds occupancy, high-watermark and sticky error reporting for debug.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2; equals the router FIFO depth.
- ADDR_W, 6, activation-index field width (low bits of the route address).
- DATA_W, 16, activation data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- push_act  in  1  write the entry on act this cycle.
- act  in  ADDR_W+DATA_W  pushed entry; {addr, data}, addr in the MSBs.
- pop_act  in  1  remove the head entry this cycle.
- flush  in  1  discard all contents (pulsed on layer start).
- act_valid  out  1  queue non-empty; head outputs are valid.
- head_addr  out  ADDR_W  activation index of the head entry.
- head_data  out  DATA_W  activation data of the head entry.
- full  out  1  count == DEPTH.
- count  out  log2(DEPTH)+1  current occupancy.
- max_count  out  log2(DEPTH)+1  high-watermark since the last rst/flush.
- overflow_err  out  1  sticky: a push was dropped because the queue was full.
- underflow_err  out  1  sticky: pop was asserted while empty.

Behaviour:
- All state is updated on posedge clk. rst has priority over everything.
- Reset values: count=0, max_count=0, read/write pointers=0, act_valid=0, full=0, head_addr=0, head_data=0, overflow_err=0, underflow_err=0. Storage contents are don't-care.
- Storage: circular buffer with wrapping pointers of width log2(DEPTH). count is held explicitly, so full and empty are decoded from count, not from pointer comparison.
- First-word-fall-through:
  - act_valid = (count != 0).
  - head_addr/head_data are driven combinationally from mem[rd_ptr], gated to 0 when empty.
  - Push-to-visible latency is 1 cycle: a push into an empty queue at cycle N gives act_valid=1 at N+1.
- Pop with count>0: rd_ptr advances and the next entry is visible the following cycle.
- Pop with count==0: ignored (no pointer or count change); underflow_err is set.
- Push with count<DEPTH: mem[wr_ptr] <= act, wr_ptr advances.
- Push with count==DEPTH and no pop: entry dropped, state unchanged, overflow_err is set.
- Push and pop in the same cycle:
  - Both are performed when count>0; count is unchanged. This holds at full too (push accepted, no overflow).
  - When count==0: the push is performed, the pop is treated as underflow, and count becomes 1.
- Count update: +1 for push only, −1 for pop only, unchanged otherwise.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.
- max_count: updated to the next-cycle count whenever that value exceeds the current max_count.
- Flush (lower priority than rst, higher than push/pop):
  - Next cycle: pointers=0, count=0, max_count=0, act_valid=0.
  - Any push or pop in the flush cycle is discarded with no error flagging.
  - Sticky error flags are NOT cleared by flush; only rst clears them.
- Sticky errors stay asserted until rst.
- No combinational path from push_act or pop_act to any output except via state. Outputs are registered state or a mux on registered state.

Test Plan:
- Reset then idle: rst for 2 cycles -> act_valid=0, count=0, full=0, both error flags 0, head outputs 0.
- Push/pop order, DEPTH=4:
  - push {3,0x0011},{5,0x0022},{7,0x0033} on consecutive cycles -> count=3, max_count=3, head=(3,0x0011).
  - Three pops -> heads 0x0011, 0x0022, 0x0033 in order; act_valid deasserts the cycle after the 3rd pop.
- Full and overflow: push 4 entries -> full=1, count=4.
  - 5th push alone -> dropped; overflow_err=1; count stays 4; head unchanged.
  - Next cycle push+pop -> count 4, no new error, new entry at tail.
- Wrap-around: alternate 1 push / 1 pop for 10 cycles with data 0..9 -> every popped value equals the push order; count never exceeds 1; max_count=1.
- Simultaneous at empty / underflow:
  - pop alone on empty -> underflow_err=1, count 0.
  - push+pop on empty -> count=1, head=pushed entry.
- Flush: with 3 entries, assert flush together with a push -> next cycle count=0, max_count=0, act_valid=0; the pushed entry is absent; the sticky flags from earlier tests are still set.
